// File: rtl/icmp_ping_agent.sv
// icmp_ping_agent: probe generator and echo checker on the ICMP user side.
// Sends patterned probes, checks the echoes, and keeps result counters.
module icmp_ping_agent #(
   parameter logic [15:0] PAYLOAD_LEN = 16'd32,
   parameter logic [31:0] TIMEOUT_CYC = 32'd125_000_000,
   parameter logic [31:0] GAP_CYC     = 32'd1_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] probe_num,
   output logic        tx_start_en,
   output logic [15:0] tx_byte_num,
   output logic [7:0]  tx_data,
   input  logic        tx_req,
   input  logic        tx_done,
   input  logic        rec_en,
   input  logic [7:0]  rec_data,
   input  logic [15:0] rec_byte_num,
   input  logic        rec_pkt_done,
   output logic        busy,
   output logic        run_done,
   output logic [15:0] sent_cnt,
   output logic [15:0] ok_cnt,
   output logic [15:0] err_cnt,
   output logic [15:0] tmo_cnt,
   output logic [31:0] rtt_last
);

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_TX,
      WAIT_RX,
      GAP,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [15:0] probe_lat;
   logic [15:0] tx_idx;
   logic [15:0] rx_cnt;
   logic [7:0]  k_r;
   logic        bad_r;
   logic        retry_r;
   logic [31:0] rtt_cnt;
   logic [31:0] cyc_cnt;

   logic        accept;
   logic        tx_fin;
   logic        rx_fin;
   logic        rx_ok;
   logic        tmo_hit;
   logic        gap_end;
   logic        timing;
   logic        rx_bad_now;
   logic        rx_bad_all;
   logic [15:0] rx_cnt_nxt;
   logic [7:0]  rx_exp;

   assign tx_byte_num = PAYLOAD_LEN;
   assign busy = (state == SEND) || (state == WAIT_TX) ||
                 (state == WAIT_RX) || (state == GAP);

   // A byte arriving with rec_pkt_done still counts toward the verdict.
   always_comb begin
      rx_exp     = k_r + rx_cnt[7:0];
      rx_bad_now = rec_en &&
                   ((rx_cnt >= PAYLOAD_LEN) || (rec_data != rx_exp));
      rx_bad_all = bad_r | rx_bad_now;
      rx_cnt_nxt = rx_cnt;
      if (rec_en && (rx_cnt < PAYLOAD_LEN))
         rx_cnt_nxt = rx_cnt + 16'd1;
      rx_ok   = !rx_bad_all &&
                (rx_cnt_nxt == PAYLOAD_LEN) &&
                (rec_byte_num == PAYLOAD_LEN);
      tmo_hit = (cyc_cnt + 32'd1) >= TIMEOUT_CYC;
      gap_end = (cyc_cnt + 32'd1) >= GAP_CYC;
      timing  = (state == WAIT_TX) || (state == WAIT_RX) ||
                (state == GAP);
      accept  = (state == IDLE) && start;
      tx_fin  = (state == WAIT_TX) && tx_done;
      rx_fin  = (state == WAIT_RX) && rec_pkt_done;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start)
               state_nxt = (probe_num == 16'd0) ? DONE : SEND;
         end
         SEND: state_nxt = WAIT_TX;
         WAIT_TX: begin
            if (tx_done)
               state_nxt = WAIT_RX;
            else if (tmo_hit)
               state_nxt = GAP;
         end
         WAIT_RX: begin
            if (rec_pkt_done || tmo_hit)
               state_nxt = GAP;
         end
         GAP: begin
            if (gap_end) begin
               if (retry_r || (sent_cnt < probe_lat))
                  state_nxt = SEND;
               else
                  state_nxt = DONE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Shared per-state cycle counter: timeout in WAIT_*, spacing in GAP.
   always_ff @(posedge clk) begin
      if (!rst_n)
         cyc_cnt <= '0;
      else if (state_nxt != state)
         cyc_cnt <= '0;
      else if (timing)
         cyc_cnt <= cyc_cnt + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_start_en <= 1'b0;
         run_done    <= 1'b0;
      end else begin
         tx_start_en <= (state == SEND);
         run_done    <= (state == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         probe_lat <= '0;
         k_r       <= '0;
         retry_r   <= 1'b0;
      end else begin
         if (accept && (probe_num != 16'd0))
            probe_lat <= probe_num;
         if (state == SEND) begin
            k_r     <= sent_cnt[7:0];
            retry_r <= 1'b0;
         end else if ((state == WAIT_TX) && !tx_done && tmo_hit) begin
            retry_r <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_idx  <= '0;
         tx_data <= '0;
      end else if (state == SEND) begin
         tx_idx <= '0;
      end else if ((state == WAIT_TX) && tx_req) begin
         tx_data <= k_r + tx_idx[7:0];
         if (tx_idx < (PAYLOAD_LEN - 16'd1))
            tx_idx <= tx_idx + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_cnt <= '0;
         bad_r  <= 1'b0;
      end else if (state == SEND) begin
         rx_cnt <= '0;
         bad_r  <= 1'b0;
      end else if (state == WAIT_RX) begin
         rx_cnt <= rx_cnt_nxt;
         bad_r  <= rx_bad_all;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rtt_cnt <= '0;
      end else if (state == SEND) begin
         rtt_cnt <= '0;
      end else if ((state == WAIT_TX) || (state == WAIT_RX)) begin
         if (rtt_cnt != 32'hFFFF_FFFF)
            rtt_cnt <= rtt_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sent_cnt <= '0;
         ok_cnt   <= '0;
         err_cnt  <= '0;
         tmo_cnt  <= '0;
         rtt_last <= '0;
      end else if (accept && (probe_num != 16'd0)) begin
         sent_cnt <= '0;
         ok_cnt   <= '0;
         err_cnt  <= '0;
         tmo_cnt  <= '0;
         rtt_last <= '0;
      end else if (tx_fin) begin
         sent_cnt <= sent_cnt + 16'd1;
      end else if (rx_fin) begin
         if (rx_ok) begin
            ok_cnt   <= ok_cnt + 16'd1;
            rtt_last <= rtt_cnt;
         end else begin
            err_cnt <= err_cnt + 16'd1;
         end
      end else if (((state == WAIT_TX) || (state == WAIT_RX)) && tmo_hit) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_icmp_ping_agent.sv
// Directed bench for icmp_ping_agent: a bench-side transmitter and echo
// model, with scoreboard queues for payload bytes and end-of-run results.
module tb_icmp_ping_agent;

   localparam logic [15:0] L   = 16'd32;
   localparam logic [31:0] TMO = 32'd100;
   localparam logic [31:0] GAP = 32'd10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] probe_num = '0;
   logic        tx_req = 1'b0;
   logic        tx_done = 1'b0;
   logic        rec_en = 1'b0;
   logic [7:0]  rec_data = '0;
   logic [15:0] rec_byte_num = '0;
   logic        rec_pkt_done = 1'b0;

   logic        tx_start_en;
   logic [15:0] tx_byte_num;
   logic [7:0]  tx_data;
   logic        busy;
   logic        run_done;
   logic [15:0] sent_cnt;
   logic [15:0] ok_cnt;
   logic [15:0] err_cnt;
   logic [15:0] tmo_cnt;
   logic [31:0] rtt_last;

   icmp_ping_agent #(
      .PAYLOAD_LEN(L),
      .TIMEOUT_CYC(TMO),
      .GAP_CYC(GAP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .probe_num(probe_num),
      .tx_start_en(tx_start_en),
      .tx_byte_num(tx_byte_num),
      .tx_data(tx_data),
      .tx_req(tx_req),
      .tx_done(tx_done),
      .rec_en(rec_en),
      .rec_data(rec_data),
      .rec_byte_num(rec_byte_num),
      .rec_pkt_done(rec_pkt_done),
      .busy(busy),
      .run_done(run_done),
      .sent_cnt(sent_cnt),
      .ok_cnt(ok_cnt),
      .err_cnt(err_cnt),
      .tmo_cnt(tmo_cnt),
      .rtt_last(rtt_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] sent;
      logic [15:0] ok;
      logic [15:0] err;
      logic [15:0] tmo;
      logic [31:0] rtt;
   } res_t;

   res_t       res_q[$];
   res_t       mon_r;
   logic [7:0] txe_q[$];
   logic [7:0] echo_q[$];

   int   pass_cnt = 0;
   int   tot_cnt = 0;
   int   starts = 0;
   int   cyc = 0;
   logic req_seen = 1'b0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      req_seen <= tx_req;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tot_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      tot_cnt++;
      $display("FAIL %s: event missing or unexpected", nm);
   endtask

   task automatic summary();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   endtask

   // Monitor: payload bytes one cycle after each request, results on run_done.
   always @(negedge clk) begin
      if (tx_start_en)
         starts++;
      if (req_seen) begin
         echo_q.push_back(tx_data);
         if (txe_q.size() == 0)
            fail("tx_data_unexpected");
         else
            chk("tx_data", {24'd0, tx_data}, {24'd0, txe_q.pop_front()});
      end
      if (run_done) begin
         if (res_q.size() == 0) begin
            fail("run_done_unexpected");
         end else begin
            mon_r = res_q.pop_front();
            chk("sent_cnt", {16'd0, sent_cnt}, {16'd0, mon_r.sent});
            chk("ok_cnt", {16'd0, ok_cnt}, {16'd0, mon_r.ok});
            chk("err_cnt", {16'd0, err_cnt}, {16'd0, mon_r.err});
            chk("tmo_cnt", {16'd0, tmo_cnt}, {16'd0, mon_r.tmo});
            chk("rtt_last", rtt_last, mon_r.rtt);
         end
      end
   end

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_run_done"}, {31'd0, run_done}, 32'd0);
      chk({tag, "_tx_start_en"}, {31'd0, tx_start_en}, 32'd0);
      chk({tag, "_tx_byte_num"}, {16'd0, tx_byte_num}, {16'd0, L});
      chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
      chk({tag, "_sent"}, {16'd0, sent_cnt}, 32'd0);
      chk({tag, "_ok"}, {16'd0, ok_cnt}, 32'd0);
      chk({tag, "_err"}, {16'd0, err_cnt}, 32'd0);
      chk({tag, "_tmo"}, {16'd0, tmo_cnt}, 32'd0);
      chk({tag, "_rtt"}, rtt_last, 32'd0);
   endtask

   task automatic go(input logic [15:0] n, output int s);
      start = 1'b1;
      probe_num = n;
      s = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_start_en(output int a);
      int n = 0;
      while (!tx_start_en) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            fail("tx_start_en_wait");
            summary();
         end
      end
      a = cyc;
   endtask

   task automatic wait_run_done(output int t);
      int n = 0;
      while (!run_done) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            fail("run_done_wait");
            summary();
         end
      end
      t = cyc;
      @(negedge clk);
   endtask

   // One probe: serve nreq payload requests, finish tx, optionally echo.
   task automatic do_probe(input int k, input int nreq, input int bad_idx,
                           input logic [7:0] bad_val,
                           input logic [15:0] rbn, input bit echo,
                           input int dly, output int rtt);
      int a;
      int b;
      wait_start_en(a);
      for (int i = 0; i < nreq; i++) begin
         b = (i < int'(L)) ? i : int'(L) - 1;
         tx_req = 1'b1;
         txe_q.push_back(8'(k + b));
         @(negedge clk);
      end
      tx_req = 1'b0;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      rtt = 0;
      if (echo) begin
         repeat (dly) @(negedge clk);
         for (int j = 0; j < int'(L); j++) begin
            rec_en = 1'b1;
            rec_data = (j == bad_idx) ? bad_val : echo_q[j];
            rec_byte_num = rbn;
            rec_pkt_done = (j == int'(L) - 1);
            if (j == int'(L) - 1)
               rtt = cyc - a;
            @(negedge clk);
         end
         rec_en = 1'b0;
         rec_pkt_done = 1'b0;
      end
      echo_q.delete();
   endtask

   initial begin
      int s;
      int t;
      int r0;
      int r1;
      int r2;
      int st;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("reset");

      // Three-probe loopback; first probe over-requests by one byte.
      go(16'd3, s);
      chk("busy_rise", {31'd0, busy}, 32'd1);
      start = 1'b1;
      probe_num = 16'd7;
      @(negedge clk);
      start = 1'b0;
      probe_num = 16'd3;
      chk("tx_start_lat", {31'd0, tx_start_en}, 32'd1);
      do_probe(0, 33, -1, 8'h00, L, 1'b1, 0, r0);
      do_probe(1, 32, -1, 8'h00, L, 1'b1, 2, r1);
      do_probe(2, 32, -1, 8'h00, L, 1'b1, 5, r2);
      res_q.push_back('{16'd3, 16'd3, 16'd0, 16'd0, 32'(r2)});
      wait_run_done(t);
      chk("starts_run1", 32'(starts), 32'd3);

      // Byte 5 of probe 0 corrupted.
      go(16'd2, s);
      do_probe(0, 32, 5, 8'hAA, L, 1'b1, 0, r0);
      do_probe(1, 32, -1, 8'h00, L, 1'b1, 3, r1);
      res_q.push_back('{16'd2, 16'd1, 16'd1, 16'd0, 32'(r1)});
      wait_run_done(t);

      // Reported length one short while data matches.
      go(16'd1, s);
      do_probe(0, 32, -1, 8'h00, L - 16'd1, 1'b1, 0, r0);
      res_q.push_back('{16'd1, 16'd0, 16'd1, 16'd0, 32'd0});
      wait_run_done(t);

      // No echo at all: both probes time out in WAIT_RX.
      go(16'd2, s);
      do_probe(0, 32, -1, 8'h00, L, 1'b0, 0, r0);
      do_probe(1, 32, -1, 8'h00, L, 1'b0, 0, r1);
      res_q.push_back('{16'd2, 16'd0, 16'd0, 16'd2, 32'd0});
      wait_run_done(t);

      // Packet completes in the very cycle the timeout expires.
      go(16'd1, s);
      do_probe(0, 32, -1, 8'h00, L, 1'b1, int'(TMO) - int'(L), r0);
      res_q.push_back('{16'd1, 16'd1, 16'd0, 16'd0, 32'(r0)});
      wait_run_done(t);

      // Zero probes: immediate run_done, counters hold.
      res_q.push_back('{16'd1, 16'd1, 16'd0, 16'd0, 32'(r0)});
      st = starts;
      go(16'd0, s);
      chk("zero_busy", {31'd0, busy}, 32'd0);
      wait_run_done(t);
      chk("zero_done_lat", 32'(t), 32'(s + 2));
      chk("zero_no_tx", 32'(starts), 32'(st));

      // Reset pulse while waiting for the echo.
      go(16'd1, s);
      do_probe(0, 32, -1, 8'h00, L, 1'b0, 0, r0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_idle("midrst");
      repeat (TMO + 20) @(negedge clk);

      // Clean run after the reset.
      go(16'd1, s);
      do_probe(0, 32, -1, 8'h00, L, 1'b1, 1, r0);
      res_q.push_back('{16'd1, 16'd1, 16'd0, 16'd0, 32'(r0)});
      wait_run_done(t);
      chk("queue_drained", 32'(res_q.size() + txe_q.size()), 32'd0);

      summary();
   end

endmodule

// File: doc/icmp_ping_agent.md
# icmp_ping_agent

Probe generator and echo checker on the user side of the ICMP Ethernet block. On a start request it issues a programmable number of probe packets through the transmit user interface (`tx_start_en` / `tx_req` / `tx_data`). It then checks each returning packet on the receive user interface (`rec_en` / `rec_data` / `rec_pkt_done`) against the known payload pattern. It keeps pass, fail and timeout counts and the last round-trip time, for link bring-up and board-to-board loopback tests.

## Interface
Parameters:
- `PAYLOAD_LEN`, 16'd32: payload bytes per probe. Legal range 1..1472.
- `TIMEOUT_CYC`, 32'd125_000_000: maximum cycles in WAIT_TX or WAIT_RX before a probe is declared timed out.
- `GAP_CYC`, 32'd1_000: idle cycles between probes.

Ports (one clock; reset is synchronous and active-low; GMII rx and tx clocks are the same net in this design):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `start`  in  1  one-cycle pulse that begins a run; ignored while `busy`.
- `probe_num`  in  16  number of probes per run, sampled on `start`.
- `tx_start_en`  out  1  one-cycle pulse that starts a transmit.
- `tx_byte_num`  out  16  equal to `PAYLOAD_LEN`; constant.
- `tx_data`  out  8  payload byte, registered.
- `tx_req`  in  1  transmitter requests the next payload byte.
- `tx_done`  in  1  transmitter finished the packet.
- `rec_en`  in  1  `rec_data` valid.
- `rec_data`  in  8  received payload byte.
- `rec_byte_num`  in  16  received payload length, valid with `rec_pkt_done`.
- `rec_pkt_done`  in  1  received packet complete.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE.
- `run_done`  out  1  one-cycle pulse at the end of a run.
- `sent_cnt`  out  16  probes transmitted in this run.
- `ok_cnt`  out  16  probes echoed correctly.
- `err_cnt`  out  16  probes echoed with a wrong length or wrong data.
- `tmo_cnt`  out  16  probes that timed out.
- `rtt_last`  out  32  cycles from `tx_start_en` to `rec_pkt_done` for the last good probe; saturating.

## Operation
- Reset values: all outputs 0, except `tx_byte_num` = `PAYLOAD_LEN`.
- State machine: IDLE, SEND, WAIT_TX, WAIT_RX, GAP, DONE.
- IDLE:
  - On `start` with `probe_num`≠0: latch `probe_num`, clear all four counters and `rtt_last`, go to SEND.
  - On `start` with `probe_num`=0: go straight to DONE.
- SEND:
  - Assert `tx_start_en` for exactly 1 cycle.
  - Clear the payload index, the rx byte counter, the mismatch flag and the RTT counter.
  - Go to WAIT_TX.
- Payload pattern: byte i of probe k is (k[7:0] + i) mod 256, with k = 0,1,2,… equal to `sent_cnt` at SEND.
- WAIT_TX:
  - Each cycle `tx_req` is high, `tx_data` takes the next pattern byte on the following edge and the index increments.
  - Requests beyond `PAYLOAD_LEN` repeat the last byte.
  - On `tx_done`: increment `sent_cnt`, go to WAIT_RX.
- WAIT_RX checking:
  - Each `rec_en` byte is compared with pattern byte j, where j is the rx byte counter; any mismatch sets a sticky flag.
  - Bytes beyond `PAYLOAD_LEN` set the flag.
- WAIT_RX on `rec_pkt_done`, the probe is OK only if all of these hold:
  - flag clear;
  - rx count = `PAYLOAD_LEN`;
  - `rec_byte_num` = `PAYLOAD_LEN`.
- WAIT_RX results:
  - OK: `ok_cnt`++ and `rtt_last` is updated.
  - Otherwise: `err_cnt`++.
  - Either way, go to GAP.
- Timeout: a counter cleared on entry to WAIT_TX and on entry to WAIT_RX. Reaching `TIMEOUT_CYC` in either state gives `tmo_cnt`++ and a move to GAP.
- `rec_*` inputs are ignored outside WAIT_RX.
- GAP:
  - Wait `GAP_CYC` cycles.
  - Then go to SEND if `sent_cnt` < latched `probe_num`.
  - Also go to SEND if the last probe timed out in WAIT_TX (unsent probe is retried). A WAIT_TX timeout does not increment `sent_cnt`, so it does not advance the pattern index k.
  - Otherwise go to DONE.
- DONE: pulse `run_done` for 1 cycle, drop `busy`, return to IDLE. Counters hold until the next accepted `start`.
- Counter widths:
  - All counters are 16-bit wrapping.
  - The RTT counter is 32-bit and saturates at 0xFFFF_FFFF.
  - The timeout counter is 32-bit.

## Timing
- `busy` rises 1 cycle after `start`; `tx_start_en` pulses 2 cycles after `start`.
- `tx_data` latency: 1 cycle after the `tx_req` cycle.
- RTT counter: 0 in the cycle `tx_start_en` is high, increments every cycle, sampled into `rtt_last` on the `rec_pkt_done` edge.
- `rec_pkt_done` in the same cycle as timeout expiry: `rec_pkt_done` wins and no timeout is counted.
- `rec_en` in the same cycle as `rec_pkt_done`: that byte is included in the check.
- `tx_done` and `rec_pkt_done` in the same cycle (in WAIT_TX): `rec_pkt_done` is ignored.
- `rst_n` low mid-run: on the next edge all state returns to IDLE with reset values and no `run_done` pulse.
- Back-to-back `start` pulses while busy are ignored.

## Test plan
- Loopback echo, `PAYLOAD_LEN`=32, `probe_num`=3 → 3 `tx_start_en` pulses; probe 1 bytes are 0x01..0x20; `ok_cnt`=3, `err_cnt`=`tmo_cnt`=0, `sent_cnt`=3; one `run_done` pulse.
- Echo with byte 5 of probe 0 corrupted to 0xAA → `err_cnt`=1, `ok_cnt`=`probe_num`−1; `rtt_last` reflects the last good probe.
- Echo with `rec_byte_num`=31 → `err_cnt`++ even though all data bytes match.
- No echo, `TIMEOUT_CYC`=100, `probe_num`=2 → `tmo_cnt`=2, `ok_cnt`=0; `run_done` after 2×(100+`GAP_CYC`) cycles plus transmit time.
- `rec_pkt_done` in the exact timeout-expiry cycle → `ok_cnt`++, `tmo_cnt` unchanged; `start` with `probe_num`=0 → `run_done` 2 cycles later, no `tx_start_en`.
- `rst_n` low for 1 cycle during WAIT_RX → all outputs return to their reset values; a new `start` runs cleanly.
